// File: rtl/video_dnn_frame_vote_if.sv
// Stream and result handshake bundle for video_dnn_frame_vote.
// The master side drives pixels and m_ready. The slave side is the vote block.
interface video_dnn_frame_vote_if #(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TNUMBER_WIDTH = 4,
  parameter int unsigned TCOUNT_WIDTH  = 4,
  parameter int unsigned VOTE_WIDTH    = 20
);
  logic [TUSER_WIDTH-1:0]   s_tuser;
  logic                     s_tlast;
  logic [TNUMBER_WIDTH-1:0] s_tnumber;
  logic [TCOUNT_WIDTH-1:0]  s_tcount;
  logic                     s_tvalid;
  logic                     s_tready;
  logic [TNUMBER_WIDTH-1:0] m_number;
  logic [VOTE_WIDTH-1:0]    m_votes;
  logic                     m_overrun;
  logic                     m_valid;
  logic                     m_ready;

  modport master (
    output s_tuser, s_tlast, s_tnumber, s_tcount, s_tvalid, m_ready,
    input  s_tready, m_number, m_votes, m_overrun, m_valid
  );

  modport slave (
    input  s_tuser, s_tlast, s_tnumber, s_tcount, s_tvalid, m_ready,
    output s_tready, m_number, m_votes, m_overrun, m_valid
  );
endinterface

// File: rtl/video_dnn_frame_vote.sv
// Per-frame class vote with a sequential argmax and one result per frame.
// Define VIDEO_DNN_FRAME_VOTE_THRESHOLD_EN to gate votes on s_tcount >= param_threshold.
module video_dnn_frame_vote #(
  parameter int unsigned NUM_CLASS     = 10,
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TNUMBER_WIDTH = 4,
  parameter int unsigned TCOUNT_WIDTH  = 4,
  parameter int unsigned VOTE_WIDTH    = 20,
  parameter int unsigned LINE_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LINE_WIDTH-1:0]   param_height,
  input  logic [TCOUNT_WIDTH-1:0] param_threshold,
  video_dnn_frame_vote_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COUNT, SEARCH, LOAD} state_t;

  state_t                   state_q, state_d;
  logic                     in_frame_q, in_frame_d;
  logic [LINE_WIDTH-1:0]    line_q, line_d;
  logic [LINE_WIDTH-1:0]    height_q, height_d;
  logic [TNUMBER_WIDTH-1:0] k_q, k_d;
  logic [TNUMBER_WIDTH-1:0] best_num_q, best_num_d;
  logic [VOTE_WIDTH-1:0]    best_votes_q, best_votes_d;
  logic [VOTE_WIDTH-1:0]    cnt_q [NUM_CLASS];
  logic [VOTE_WIDTH-1:0]    cnt_d [NUM_CLASS];
  logic                     tready_q, tready_d;
  logic [TNUMBER_WIDTH-1:0] m_number_q, m_number_d;
  logic [VOTE_WIDTH-1:0]    m_votes_q, m_votes_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_overrun_q, m_overrun_d;

  logic                     accept, sof, counting, thr_ok, vote;
  logic [LINE_WIDTH-1:0]    height_new, line_new;
  logic [VOTE_WIDTH-1:0]    search_val;
  logic                     unused_tuser;

  assign accept   = bus.s_tvalid & tready_q;
  assign sof      = accept & bus.s_tuser[0];
  // Beats only count once a frame start has been seen since reset or the last LOAD.
  assign counting = accept & (sof | in_frame_q);

`ifdef VIDEO_DNN_FRAME_VOTE_THRESHOLD_EN
  assign thr_ok = (bus.s_tcount >= param_threshold);
  assign unused_tuser = ^bus.s_tuser;
`else
  assign thr_ok = 1'b1;
  assign unused_tuser = ^{bus.s_tuser, bus.s_tcount, param_threshold};
`endif

  assign vote       = counting & thr_ok & (32'(bus.s_tnumber) < NUM_CLASS);
  assign height_new = sof ? ((param_height == '0) ? LINE_WIDTH'(1) : param_height) : height_q;
  assign line_new   = (sof ? '0 : line_q) + LINE_WIDTH'(1);

  always_comb begin
    search_val = '0;
    for (int unsigned i = 0; i < NUM_CLASS; i++) begin
      if (k_q == TNUMBER_WIDTH'(i)) search_val = cnt_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    in_frame_d   = in_frame_q;
    line_d       = line_q;
    height_d     = height_q;
    k_d          = k_q;
    best_num_d   = best_num_q;
    best_votes_d = best_votes_q;
    cnt_d        = cnt_q;
    tready_d     = tready_q;
    m_number_d   = m_number_q;
    m_votes_d    = m_votes_q;
    m_valid_d    = m_valid_q;
    m_overrun_d  = m_overrun_q;

    if (m_valid_q && bus.m_ready) begin
      m_valid_d   = 1'b0;
      m_overrun_d = 1'b0;
    end

    case (state_q)
      IDLE, COUNT: begin
        tready_d = 1'b1;
        if (sof) begin
          state_d    = COUNT;
          in_frame_d = 1'b1;
          height_d   = height_new;
          line_d     = '0;
          for (int unsigned i = 0; i < NUM_CLASS; i++) cnt_d[i] = '0;
        end
        // Frame-start clear above happens first so the SOF pixel votes into a fresh counter.
        if (vote) begin
          for (int unsigned i = 0; i < NUM_CLASS; i++) begin
            if (bus.s_tnumber == TNUMBER_WIDTH'(i) && cnt_d[i] != '1)
              cnt_d[i] = cnt_d[i] + VOTE_WIDTH'(1);
          end
        end
        if (counting && bus.s_tlast) begin
          if (line_new == height_new) begin
            state_d      = SEARCH;
            tready_d     = 1'b0;
            in_frame_d   = 1'b0;
            k_d          = '0;
            best_num_d   = '0;
            best_votes_d = '0;
          end else begin
            line_d = line_new;
          end
        end
      end
      SEARCH: begin
        tready_d = 1'b0;
        if (search_val > best_votes_q) begin
          best_num_d   = k_q;
          best_votes_d = search_val;
        end
        if (k_q == TNUMBER_WIDTH'(NUM_CLASS - 1)) state_d = LOAD;
        else k_d = k_q + TNUMBER_WIDTH'(1);
      end
      LOAD: begin
        tready_d    = 1'b1;
        state_d     = COUNT;
        m_number_d  = best_num_q;
        m_votes_d   = best_votes_q;
        m_valid_d   = 1'b1;
        m_overrun_d = m_valid_q & ~bus.m_ready;
        for (int unsigned i = 0; i < NUM_CLASS; i++) cnt_d[i] = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      in_frame_q   <= 1'b0;
      line_q       <= '0;
      height_q     <= LINE_WIDTH'(1);
      k_q          <= '0;
      best_num_q   <= '0;
      best_votes_q <= '0;
      for (int unsigned i = 0; i < NUM_CLASS; i++) cnt_q[i] <= '0;
      tready_q     <= 1'b0;
      m_number_q   <= '0;
      m_votes_q    <= '0;
      m_valid_q    <= 1'b0;
      m_overrun_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_frame_q   <= in_frame_d;
      line_q       <= line_d;
      height_q     <= height_d;
      k_q          <= k_d;
      best_num_q   <= best_num_d;
      best_votes_q <= best_votes_d;
      cnt_q        <= cnt_d;
      tready_q     <= tready_d;
      m_number_q   <= m_number_d;
      m_votes_q    <= m_votes_d;
      m_valid_q    <= m_valid_d;
      m_overrun_q  <= m_overrun_d;
    end
  end

  assign bus.s_tready  = tready_q;
  assign bus.m_number  = m_number_q;
  assign bus.m_votes   = m_votes_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_overrun = m_overrun_q;

endmodule
